// File: rtl/vga_mode_pkg.sv
// Shared definitions for the VGA mode controller.
//   timing_t      : one row of the mode timing table
//   state_t       : controller FSM encoding
//   MODE_NUM      : number of legal modes (0..MODE_NUM-1); 7 is illegal
//   mode_timing() : mode index -> timing row
package vga_mode_pkg;

    localparam int MODE_NUM = 7;

    typedef struct packed {
        logic [11:0] h_active;
        logic [7:0]  h_fp;
        logic [7:0]  h_sync;
        logic [7:0]  h_bp;
        logic [11:0] v_active;
        logic [7:0]  v_fp;
        logic [7:0]  v_sync;
        logic [7:0]  v_bp;
        logic        hs_pol;   // 1 = positive sync pulse
        logic        vs_pol;
    } timing_t;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_FRAME,
        ST_BLANK,
        ST_PLL_REQ,
        ST_PLL_WAIT,
        ST_PLL_DROP,   // attempt timed out: wait for ack low, then retry or fall back
        ST_SETTLE
    } state_t;

    function automatic timing_t mode_timing(input logic [2:0] m);
        timing_t t;
        case (m)
            3'd0:    t = '{12'd640,  8'd16, 8'd96,  8'd48,  12'd480,  8'd10, 8'd2, 8'd33, 1'b0, 1'b0};
            3'd1:    t = '{12'd640,  8'd16, 8'd64,  8'd120, 12'd480,  8'd1,  8'd3, 8'd16, 1'b0, 1'b0};
            3'd2:    t = '{12'd800,  8'd40, 8'd128, 8'd88,  12'd600,  8'd1,  8'd4, 8'd23, 1'b1, 1'b1};
            3'd3:    t = '{12'd800,  8'd16, 8'd80,  8'd160, 12'd600,  8'd1,  8'd3, 8'd21, 1'b1, 1'b1};
            3'd4:    t = '{12'd1024, 8'd24, 8'd136, 8'd160, 12'd768,  8'd3,  8'd6, 8'd29, 1'b0, 1'b0};
            3'd5:    t = '{12'd1440, 8'd80, 8'd152, 8'd232, 12'd900,  8'd1,  8'd3, 8'd28, 1'b0, 1'b1};
            default: t = '{12'd1920, 8'd88, 8'd44,  8'd148, 12'd1080, 8'd4,  8'd5, 8'd36, 1'b1, 1'b1};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Bus between the mode controller and its surroundings (request port,
// PLL reconfig handshake, frame toggle, timing fields to the sync generator).
//   master : the controller (vga_mode_ctrl)
//   slave  : requester / PLL / sync generator side
interface vga_mode_ctrl_if;
    logic [2:0]  mode_sel;
    logic        mode_req;
    logic        frame_tgl;
    logic        pll_locked;
    logic        pll_cfg_ack;
    logic        pll_cfg_req;
    logic [2:0]  pll_cfg_sel;
    logic        sync_rst_n;
    logic        busy;
    logic        err;
    logic [2:0]  cur_mode;
    logic [11:0] tim_h_active, tim_v_active;
    logic [7:0]  tim_h_fp, tim_h_sync, tim_h_bp;
    logic [7:0]  tim_v_fp, tim_v_sync, tim_v_bp;
    logic        tim_hs_pol, tim_vs_pol;

    modport master (
        input  mode_sel, mode_req, frame_tgl, pll_locked, pll_cfg_ack,
        output pll_cfg_req, pll_cfg_sel, sync_rst_n, busy, err, cur_mode,
               tim_h_active, tim_v_active, tim_h_fp, tim_h_sync, tim_h_bp,
               tim_v_fp, tim_v_sync, tim_v_bp, tim_hs_pol, tim_vs_pol
    );

    modport slave (
        output mode_sel, mode_req, frame_tgl, pll_locked, pll_cfg_ack,
        input  pll_cfg_req, pll_cfg_sel, sync_rst_n, busy, err, cur_mode,
               tim_h_active, tim_v_active, tim_h_fp, tim_h_sync, tim_h_bp,
               tim_v_fp, tim_v_sync, tim_v_bp, tim_hs_pol, tim_vs_pol
    );
endinterface

// File: rtl/vga_sync_2ff.sv
// Two-flop synchroniser for slow asynchronous level signals.
//   clk, rst_n : destination clock, async active-low reset (outputs clear to 0)
//   d          : asynchronous input
//   q          : synchronised output, two clk edges behind d
module vga_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/vga_mode_ctrl.sv
// Runtime VGA resolution controller. Accepts a mode request, waits for a
// frame boundary (or a timeout), blanks the sync generator, reprograms the
// pixel PLL with a 4-phase handshake and releases the sync generator once the
// PLL lock has been stable for SETTLE_CYCLES. Failed PLL attempts are retried
// and finally fall back to DEFAULT_MODE.
//   clk, rst_n : board clock, async active-low reset
//   bus        : vga_mode_ctrl_if.master (request, PLL handshake, timing out)
module vga_mode_ctrl
    import vga_mode_pkg::*;
#(
    parameter int DEFAULT_MODE  = 6,
    parameter int FRAME_TIMEOUT = 2_000_000,
    parameter int LOCK_TIMEOUT  = 1_048_575,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_mode_ctrl_if.master bus
);
    localparam logic [2:0]  DEF         = 3'(DEFAULT_MODE);
    localparam timing_t     DEF_TIM     = mode_timing(DEF);
    localparam logic [31:0] FRAME_LAST  = 32'(FRAME_TIMEOUT - 1);
    localparam logic [31:0] LOCK_LAST   = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

    logic frame_s, locked_s, frame_prev_q, frame_edge;

    vga_sync_2ff #(.WIDTH(1)) u_sync_frame (.clk(clk), .rst_n(rst_n), .d(bus.frame_tgl),  .q(frame_s));
    vga_sync_2ff #(.WIDTH(1)) u_sync_lock  (.clk(clk), .rst_n(rst_n), .d(bus.pll_locked), .q(locked_s));

    assign frame_edge = frame_s ^ frame_prev_q;

    state_t      state_q, state_d;
    logic [2:0]  pend_q, pend_d, sel_q, sel_d, cur_q, cur_d;
    logic [7:0]  retry_q, retry_d;
    logic [31:0] cnt_q, cnt_d;   // frame timeout, lock timeout or settle count, by state
    logic        req_q, req_d, srst_q, srst_d, busy_q, busy_d, err_q, err_d;
    timing_t     tim_q, tim_d;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        retry_d = retry_q;
        cnt_d   = cnt_q + 32'd1;
        req_d   = req_q;
        sel_d   = sel_q;
        srst_d  = srst_q;
        busy_d  = busy_q;
        err_d   = err_q;
        cur_d   = cur_q;
        tim_d   = tim_q;
        case (state_q)
            ST_RUN: begin
                cnt_d = '0;
                if (bus.mode_req) begin
                    if (bus.mode_sel == 3'd7) begin
                        err_d = 1'b1;
                    end else if (bus.mode_sel != cur_q) begin
                        pend_d  = bus.mode_sel;
                        err_d   = 1'b0;
                        retry_d = '0;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT_FRAME;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                // Entered with cnt=0, so this fires after FRAME_TIMEOUT cycles here.
                if (frame_edge || cnt_q == FRAME_LAST) begin
                    srst_d  = 1'b0;
                    cur_d   = pend_q;
                    tim_d   = mode_timing(pend_q);
                    state_d = ST_BLANK;
                end
            end
            ST_BLANK: begin
                sel_d   = cur_q;
                cnt_d   = '0;
                state_d = ST_PLL_REQ;
            end
            ST_PLL_REQ: begin
                req_d = 1'b1;
                if (req_q && bus.pll_cfg_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_PLL_WAIT;
                end
                if (cnt_q == LOCK_LAST) begin
                    req_d   = 1'b0;
                    state_d = ST_PLL_DROP;
                end
            end
            ST_PLL_WAIT: begin
                if (!bus.pll_cfg_ack && locked_s) begin
                    cnt_d   = 32'd1;   // this sampled lock cycle already counts
                    state_d = ST_SETTLE;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_PLL_DROP;
                end
            end
            ST_PLL_DROP: begin
                cnt_d = '0;
                if (!bus.pll_cfg_ack) begin
                    if (pend_q == DEF) begin
                        state_d = ST_PLL_REQ;   // nothing to fall back to: keep trying
                    end else if (32'(retry_q + 8'd1) < 32'(MAX_RETRY)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_PLL_REQ;
                    end else begin
                        err_d   = 1'b1;
                        retry_d = '0;
                        pend_d  = DEF;
                        cur_d   = DEF;
                        tim_d   = DEF_TIM;
                        state_d = ST_BLANK;
                    end
                end
            end
            ST_SETTLE: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q >= SETTLE_LAST) begin
                    srst_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_PLL_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_PLL_REQ;
            pend_q       <= DEF;
            retry_q      <= '0;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            sel_q        <= DEF;
            srst_q       <= 1'b0;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
            cur_q        <= DEF;
            tim_q        <= DEF_TIM;
            frame_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            retry_q      <= retry_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            sel_q        <= sel_d;
            srst_q       <= srst_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            cur_q        <= cur_d;
            tim_q        <= tim_d;
            frame_prev_q <= frame_s;
        end
    end

    assign bus.pll_cfg_req  = req_q;
    assign bus.pll_cfg_sel  = sel_q;
    assign bus.sync_rst_n   = srst_q;
    assign bus.busy         = busy_q;
    assign bus.err          = err_q;
    assign bus.cur_mode     = cur_q;
    assign bus.tim_h_active = tim_q.h_active;
    assign bus.tim_h_fp     = tim_q.h_fp;
    assign bus.tim_h_sync   = tim_q.h_sync;
    assign bus.tim_h_bp     = tim_q.h_bp;
    assign bus.tim_v_active = tim_q.v_active;
    assign bus.tim_v_fp     = tim_q.v_fp;
    assign bus.tim_v_sync   = tim_q.v_sync;
    assign bus.tim_v_bp     = tim_q.v_bp;
    assign bus.tim_hs_pol   = tim_q.hs_pol;
    assign bus.tim_vs_pol   = tim_q.vs_pol;
endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl with a small PLL responder model:
// ack 5 clk after a request, ack drop after request drop, lock 100 clk after.
module tb_vga_mode_ctrl;
    localparam int FT = 200;
    localparam int LT = 300;
    localparam int S  = 1024;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    // PLL model state
    logic lock_raw = 1'b0, glitch = 1'b0, lock_ok = 1'b1;
    bit   req_seen = 0, lock_wait = 0;
    int   ack_cnt = 0, lk_cnt = 0, n_req = 0, n_lock = 0, lock_cyc = 0, lock_mark = 0;

    vga_mode_ctrl_if bus ();

    vga_mode_ctrl #(
        .DEFAULT_MODE(6), .FRAME_TIMEOUT(FT), .LOCK_TIMEOUT(LT),
        .SETTLE_CYCLES(S), .MAX_RETRY(2)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.pll_locked = lock_raw & ~glitch;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit cond(input int s);
        case (s)
            0:       return bus.sync_rst_n;
            1:       return bus.err;
            2:       return bus.pll_cfg_req;
            default: return n_lock != lock_mark;
        endcase
    endfunction

    // Step until condition s holds or bound expires; the final check reports a timeout.
    task automatic wait_sig(input string tag, input int s, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            step(1);
            if (cond(s)) begin
                at = cyc;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(cond(s)), 32'd1);
    endtask

    task automatic request(input logic [2:0] m);
        bus.mode_sel = m;
        bus.mode_req = 1'b1;
        step(1);
        bus.mode_req = 1'b0;
    endtask

    // PLL responder
    initial begin
        bus.pll_cfg_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pll_cfg_req && !bus.pll_cfg_ack) begin
                if (!req_seen) begin
                    req_seen  = 1;
                    n_req++;
                    lock_raw  = 1'b0;
                    lock_wait = 0;
                    ack_cnt   = 0;
                end
                ack_cnt++;
                if (ack_cnt == 5) bus.pll_cfg_ack = 1'b1;
            end else if (!bus.pll_cfg_req && bus.pll_cfg_ack) begin
                bus.pll_cfg_ack = 1'b0;
                req_seen  = 0;
                lock_wait = 1;
                lk_cnt    = 0;
            end else if (!bus.pll_cfg_req) begin
                req_seen = 0;
            end
            if (lock_wait && lock_ok) begin
                lk_cnt++;
                if (lk_cnt == 100) begin
                    lock_raw  = 1'b1;
                    lock_wait = 0;
                    lock_cyc  = cyc;
                    n_lock++;
                end
            end
        end
    end

    initial begin
        int at, rs, rl, lk, mark;
        rst_n         = 1'b0;
        bus.mode_sel  = 3'd0;
        bus.mode_req  = 1'b0;
        bus.frame_tgl = 1'b0;
        step(3);

        // reset state
        chk("rst_sync_rst_n", 32'(bus.sync_rst_n), 0);
        chk("rst_busy",       32'(bus.busy), 1);
        chk("rst_err",        32'(bus.err), 0);
        chk("rst_req",        32'(bus.pll_cfg_req), 0);
        chk("rst_cur_mode",   32'(bus.cur_mode), 6);
        chk("rst_cfg_sel",    32'(bus.pll_cfg_sel), 6);
        chk("rst_h_active",   32'(bus.tim_h_active), 1920);
        chk("rst_v_active",   32'(bus.tim_v_active), 1080);
        chk("rst_h_sync",     32'(bus.tim_h_sync), 44);
        chk("rst_v_bp",       32'(bus.tim_v_bp), 36);

        // boot: release comes S cycles after synced lock, synchroniser adds 2
        lock_mark = n_lock;
        rst_n = 1'b1;
        wait_sig("boot_lock", 3, 2000, at);
        wait_sig("boot_rise", 0, 3000, rs);
        chk("boot_settle", 32'(rs - lock_cyc), 32'(S + 2));
        chk("boot_busy", 32'(bus.busy), 0);
        chk("boot_h_active", 32'(bus.tim_h_active), 1920);

        // illegal mode
        request(3'd7);
        chk("ill_err", 32'(bus.err), 1);
        chk("ill_busy", 32'(bus.busy), 0);
        chk("ill_cur", 32'(bus.cur_mode), 6);

        // same mode: ignored
        request(3'd6);
        chk("same_busy", 32'(bus.busy), 0);
        chk("same_err", 32'(bus.err), 1);
        step(3);
        chk("same_req", 32'(bus.pll_cfg_req), 0);
        chk("same_sync", 32'(bus.sync_rst_n), 1);

        // switch to mode 2 on a frame edge
        request(3'd2);
        chk("sw_busy", 32'(bus.busy), 1);
        chk("sw_err_clr", 32'(bus.err), 0);
        step(10);
        chk("sw_wait_hold", 32'(bus.sync_rst_n), 1);
        lock_mark = n_lock;
        bus.frame_tgl = ~bus.frame_tgl;
        step(2);
        chk("sw_edge_2clk", 32'(bus.sync_rst_n), 1);
        step(1);
        chk("sw_edge_3clk", 32'(bus.sync_rst_n), 0);
        chk("sw_h_active", 32'(bus.tim_h_active), 800);
        chk("sw_v_active", 32'(bus.tim_v_active), 600);
        chk("sw_cur", 32'(bus.cur_mode), 2);
        request(3'd3);   // busy: must be ignored
        chk("busy_req_err", 32'(bus.err), 0);
        wait_sig("sw_lock", 3, 1000, at);
        chk("sw_cfg_sel", 32'(bus.pll_cfg_sel), 2);
        lk = lock_cyc;
        // glitch lock when the settle count reaches 500
        step(lk + 502 - cyc);
        glitch = 1'b1;
        step(1);
        glitch = 1'b0;
        rl = cyc;
        chk("glitch_hold", 32'(bus.sync_rst_n), 0);
        wait_sig("sw_rise", 0, 2000, rs);
        chk("glitch_restart", 32'(rs - rl), 32'(S + 2));
        chk("sw_busy_end", 32'(bus.busy), 0);
        chk("sw_cur_kept", 32'(bus.cur_mode), 2);
        chk("sw_hs_pol", 32'(bus.tim_hs_pol), 1);
        chk("sw_h_fp", 32'(bus.tim_h_fp), 40);

        // no frame edge: frame timeout
        mark = cyc;
        request(3'd0);
        step(mark + FT - cyc);
        chk("ft_hold", 32'(bus.sync_rst_n), 1);
        step(1);
        chk("ft_blank", 32'(bus.sync_rst_n), 0);
        chk("ft_h_active", 32'(bus.tim_h_active), 640);
        chk("ft_h_sync", 32'(bus.tim_h_sync), 96);
        chk("ft_vs_pol", 32'(bus.tim_vs_pol), 0);
        wait_sig("ft_rise", 0, 2000, rs);
        chk("ft_cur", 32'(bus.cur_mode), 0);

        // PLL never locks: two attempts, then fall back to mode 6
        lock_ok = 1'b0;
        mark = n_req;
        request(3'd4);
        bus.frame_tgl = ~bus.frame_tgl;
        wait_sig("fb_err", 1, 2000, at);
        chk("fb_attempts", 32'(n_req - mark), 2);
        chk("fb_cur", 32'(bus.cur_mode), 6);
        chk("fb_h_active", 32'(bus.tim_h_active), 1920);
        chk("fb_busy", 32'(bus.busy), 1);
        lock_ok = 1'b1;
        wait_sig("fb_req3", 2, 50, at);
        chk("fb_cfg_sel", 32'(bus.pll_cfg_sel), 6);
        wait_sig("fb_rise", 0, 3000, rs);
        chk("fb_attempts3", 32'(n_req - mark), 3);
        chk("fb_err_sticky", 32'(bus.err), 1);
        chk("fb_busy_end", 32'(bus.busy), 0);

        // async reset while requesting the PLL
        request(3'd3);
        bus.frame_tgl = ~bus.frame_tgl;
        wait_sig("rr_req", 2, 50, at);
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop", 32'(bus.pll_cfg_req), 0);
        chk("rr_sync", 32'(bus.sync_rst_n), 0);
        chk("rr_busy", 32'(bus.busy), 1);
        chk("rr_cur", 32'(bus.cur_mode), 6);
        chk("rr_err", 32'(bus.err), 0);
        step(2);
        rst_n = 1'b1;
        wait_sig("rr_rise", 0, 3000, rs);
        chk("rr_h_active", 32'(bus.tim_h_active), 1920);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
